// File: rtl/ddr3_fill_reader_pkg.sv
// ddr3_fill_reader_pkg: header layout, FSM states and
// defaults shared by the fill reader and its output register.
package ddr3_fill_reader_pkg;

  localparam int DATA_W = 128;

  localparam int ADDR_LSB = 0;
  localparam int ADDR_W   = 23;
  localparam int CNT_LSB  = 23;
  localparam int TAG_LSB  = 120;

  localparam int CNT_W_DEF   = 20;
  localparam int TIMEOUT_DEF = 1024;

  localparam logic [7:0] HDR_TAG_DEF = 8'hF1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_REQ,
    S_WAIT,
    S_OUT
  } state_t;

endpackage

// File: rtl/fill_rdr_out_reg.sv
// fill_rdr_out_reg: single-entry valid/ready holding register.
// Word, valid and last stay put until the consumer takes them.
module fill_rdr_out_reg #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_dat,
  input  logic         load_last,
  input  logic         ready,
  output logic [W-1:0] dat,
  output logic         valid,
  output logic         last
);

  // load a new word, or drop valid once it is taken
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dat   <= '0;
      valid <= 1'b0;
      last  <= 1'b0;
    end else if (load) begin
      dat   <= load_dat;
      valid <= 1'b1;
      last  <= load_last;
    end else if (valid && ready) begin
      valid <= 1'b0;
      last  <= 1'b0;
    end
  end

endmodule

// File: rtl/ddr3_fill_reader.sv
// ddr3_fill_reader: pops a fill header, fetches its bursts one
// at a time and streams header + bursts to the packetizer.
module ddr3_fill_reader
  import ddr3_fill_reader_pkg::*;
#(
  parameter logic [7:0] HDR_TAG = HDR_TAG_DEF,
  parameter int         TIMEOUT = TIMEOUT_DEF,
  parameter int         CNT_W   = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              acq_enabled,
  input  logic              fill_header_fifo_empty,
  output logic              fill_header_fifo_rd_en,
  input  logic [DATA_W-1:0] fill_header_fifo_out,
  output logic [ADDR_W-1:0] ddr3_rd_burst_addr,
  output logic              ddr3_rd_one_burst,
  input  logic              ddr3_one_burst_rdy,
  input  logic [DATA_W-1:0] ddr3_one_burst_data,
  output logic [DATA_W-1:0] rd_fill_dat,
  output logic              rd_fill_valid,
  input  logic              rd_fill_ready,
  output logic              rd_fill_last,
  output logic              fill_rdr_busy,
  output logic              fill_rdr_err
);

  localparam int TMO_W = $clog2(TIMEOUT) + 1;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  remain;
  logic [TMO_W-1:0]  tmo;
  logic [CNT_W-1:0]  hdr_cnt;
  logic              start;
  logic              got;
  logic              tmo_hit;
  logic              accept;
  logic              ld;
  logic              ld_last;
  logic [DATA_W-1:0] ld_dat;

  assign hdr_cnt = fill_header_fifo_out[CNT_LSB +: CNT_W];
  assign accept  = rd_fill_valid & rd_fill_ready;
  assign start   = (state == S_IDLE)
                 & ~fill_header_fifo_empty
                 & ~acq_enabled;
  assign got     = (state == S_WAIT) & ddr3_one_burst_rdy;
  assign tmo_hit = (state == S_WAIT) & ~ddr3_one_burst_rdy
                 & (tmo == TMO_W'(TIMEOUT - 1));
  assign ld      = start | got | tmo_hit;

  assign ddr3_rd_burst_addr = addr;
  assign fill_rdr_busy      = (state != S_IDLE);

  // pick the word to park in the output register; a timeout
  // parks an all-zero closing word
  always_comb begin
    ld_dat  = '0;
    ld_last = 1'b1;
    unique case (1'b1)
      start: begin
        ld_dat  = fill_header_fifo_out;
        ld_last = (hdr_cnt == '0);
      end
      got: begin
        ld_dat  = ddr3_one_burst_data;
        ld_last = (remain == CNT_W'(1));
      end
      default: ;
    endcase
  end

  // fill sequencing: header, then request/wait/emit per burst
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state                  <= S_IDLE;
      addr                   <= '0;
      remain                 <= '0;
      tmo                    <= '0;
      fill_header_fifo_rd_en <= 1'b0;
      ddr3_rd_one_burst      <= 1'b0;
      fill_rdr_err           <= 1'b0;
    end else begin
      fill_header_fifo_rd_en <= 1'b0;
      ddr3_rd_one_burst      <= 1'b0;
      if (ddr3_one_burst_rdy && state != S_WAIT)
        fill_rdr_err <= 1'b1;
      unique case (state)
        S_IDLE: if (start) begin
          state                  <= S_HDR;
          fill_header_fifo_rd_en <= 1'b1;
          addr   <= fill_header_fifo_out[ADDR_LSB +: ADDR_W];
          remain <= hdr_cnt;
          if (fill_header_fifo_out[TAG_LSB +: 8] != HDR_TAG)
            fill_rdr_err <= 1'b1;
        end
        S_HDR: if (accept) begin
          if (remain == '0) begin
            state <= S_IDLE;
          end else begin
            state             <= S_REQ;
            ddr3_rd_one_burst <= 1'b1;
          end
        end
        S_REQ: begin
          state <= S_WAIT;
          tmo   <= '0;
        end
        S_WAIT: begin
          if (got) begin
            state  <= S_OUT;
            addr   <= addr + ADDR_W'(1);
            remain <= remain - CNT_W'(1);
          end else if (tmo_hit) begin
            state        <= S_OUT;
            fill_rdr_err <= 1'b1;
          end else begin
            tmo <= tmo + TMO_W'(1);
          end
        end
        S_OUT: if (accept) begin
          if (rd_fill_last) begin
            state <= S_IDLE;
          end else begin
            state             <= S_REQ;
            ddr3_rd_one_burst <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  fill_rdr_out_reg #(
    .W (DATA_W)
  ) u_out (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (ld),
    .load_dat  (ld_dat),
    .load_last (ld_last),
    .ready     (rd_fill_ready),
    .dat       (rd_fill_dat),
    .valid     (rd_fill_valid),
    .last      (rd_fill_last)
  );

endmodule

// File: tb/tb_ddr3_fill_reader.sv
// tb_ddr3_fill_reader: directed fills against a header FIFO
// model and a fixed-latency single-burst DDR3 model.
module tb_ddr3_fill_reader;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         acq = 1'b0;
  logic         fifo_empty;
  logic         fifo_rd_en;
  logic [127:0] fifo_out;
  logic [22:0]  baddr;
  logic         one_burst;
  logic         bst_rdy = 1'b0;
  logic [127:0] bst_data = '0;
  logic [127:0] dat;
  logic         valid;
  logic         ready = 1'b1;
  logic         last;
  logic         busy;
  logic         err;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ddr3_fill_reader #(
    .TIMEOUT (16)
  ) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .acq_enabled            (acq),
    .fill_header_fifo_empty (fifo_empty),
    .fill_header_fifo_rd_en (fifo_rd_en),
    .fill_header_fifo_out   (fifo_out),
    .ddr3_rd_burst_addr     (baddr),
    .ddr3_rd_one_burst      (one_burst),
    .ddr3_one_burst_rdy     (bst_rdy),
    .ddr3_one_burst_data    (bst_data),
    .rd_fill_dat            (dat),
    .rd_fill_valid          (valid),
    .rd_fill_ready          (ready),
    .rd_fill_last           (last),
    .fill_rdr_busy          (busy),
    .fill_rdr_err           (err)
  );

  function automatic logic [127:0] mk_hdr(
    input logic [7:0] tag, input logic [19:0] n,
    input logic [22:0] a);
    return {tag, 77'd0, n, a};
  endfunction

  function automatic logic [127:0] bdat(input logic [22:0] a);
    return {8'hD0, a, 74'd0, a};
  endfunction

  // header FIFO model, first-word-fall-through
  logic [127:0] hdr_mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_out = hdr_mem[rd_ptr % 16];

  always @(negedge clk)
    if (fifo_rd_en && !fifo_empty) rd_ptr <= rd_ptr + 1;

  task automatic push(input logic [127:0] h);
    hdr_mem[wr_ptr % 16] = h;
    wr_ptr = wr_ptr + 1;
  endtask

  // DDR3 model: rdy pulse ddr_lat cycles after a request
  int ddr_lat = 5;
  int ddr_cnt = 0;
  int ovl = 0;
  int req_n = 0;
  logic [22:0] ddr_a = '0;
  logic [22:0] req_log [0:63];

  always @(negedge clk) begin
    bst_rdy = 1'b0;
    if (ddr_cnt == 1) begin
      bst_rdy  = 1'b1;
      bst_data = bdat(ddr_a);
    end
    if (ddr_cnt > 0) ddr_cnt = ddr_cnt - 1;
    if (one_burst) begin
      if (ddr_cnt != 0) ovl = ovl + 1;
      if (req_n < 64) req_log[req_n] = baddr;
      req_n = req_n + 1;
      ddr_a   = baddr;
      ddr_cnt = ddr_lat;
    end
  end

  // output monitor: log accepted words, flag unstable stalls
  logic [127:0] out_dat [0:63];
  logic         out_last [0:63];
  int out_n = 0;
  int stall_bad = 0;
  logic pv = 1'b0;
  logic pr = 1'b0;
  logic pl = 1'b0;
  logic [127:0] pd = '0;

  always @(negedge clk) begin
    if (reset_n && valid && ready) begin
      if (out_n < 64) begin
        out_dat[out_n]  = dat;
        out_last[out_n] = last;
      end
      out_n = out_n + 1;
    end
    if (pv && !pr && (!valid || dat != pd || last != pl))
      stall_bad = stall_bad + 1;
    pv = valid && reset_n;
    pr = ready;
    pd = dat;
    pl = last;
  end

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input string tag, input bit stall);
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk);
      #1;
      if (stall) ready = (i % 3 == 0);
      done = !busy && fifo_empty;
    end
    ready = 1'b1;
    chk({tag, "/done"}, done, 1);
  endtask

  task automatic expect_fill(input string tag, input int ob,
                             input int rb,
                             input logic [127:0] hdr,
                             input int nb, input bit to);
    int nw;
    int nr;
    logic [22:0] a;
    logic [127:0] ed;
    nw = to ? 2 : nb + 1;
    nr = to ? 1 : nb;
    chk({tag, "/words"}, out_n - ob, nw);
    chk({tag, "/reqs"}, req_n - rb, nr);
    for (int i = 0; i < nw && ob + i < out_n
         && ob + i < 64; i++) begin
      a  = hdr[22:0] + 23'(i - 1);
      ed = (i == 0) ? hdr : (to ? '0 : bdat(a));
      chk({tag, "/dat"}, out_dat[ob + i], ed);
      chk({tag, "/last"}, out_last[ob + i], i == nw - 1);
    end
    for (int i = 0; i < nr && rb + i < req_n
         && rb + i < 64; i++) begin
      a = hdr[22:0] + 23'(i);
      chk({tag, "/addr"}, req_log[rb + i], a);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not reach its end");
    $fatal(1);
  end

  initial begin
    logic [127:0] h;
    int ob;
    int rb;
    int p0;

    tick(3);
    chk("rst/rd_en", fifo_rd_en, 0);
    chk("rst/req", one_burst, 0);
    chk("rst/valid", valid, 0);
    chk("rst/last", last, 0);
    chk("rst/busy", busy, 0);
    chk("rst/err", err, 0);
    chk("rst/addr", baddr, 0);
    chk("rst/dat", dat, 0);
    reset_n = 1'b1;
    tick(2);

    // basic 3-burst fill
    ob = out_n; rb = req_n;
    h = mk_hdr(8'hF1, 20'd3, 23'h000010);
    push(h);
    wait_done("t1", 1'b0);
    expect_fill("t1", ob, rb, h, 3, 1'b0);
    chk("t1/err", err, 0);

    // address wrap
    ob = out_n; rb = req_n;
    h = mk_hdr(8'hF1, 20'd3, 23'h7FFFFE);
    push(h);
    wait_done("t2", 1'b0);
    expect_fill("t2", ob, rb, h, 3, 1'b0);

    // empty fill
    ob = out_n; rb = req_n;
    h = mk_hdr(8'hF1, 20'd0, 23'h000123);
    push(h);
    wait_done("t3", 1'b0);
    expect_fill("t3", ob, rb, h, 0, 1'b0);

    // stalled consumer
    ob = out_n; rb = req_n;
    h = mk_hdr(8'hF1, 20'd4, 23'h000100);
    push(h);
    wait_done("t4", 1'b1);
    expect_fill("t4", ob, rb, h, 4, 1'b0);
    chk("t4/stall", stall_bad, 0);
    chk("t4/outstanding", ovl, 0);
    chk("t4/err", err, 0);

    // acquisition gating
    ob = out_n; rb = req_n;
    acq = 1'b1;
    h = mk_hdr(8'hF1, 20'd1, 23'h000040);
    push(h);
    p0 = rd_ptr;
    tick(5);
    chk("t6/nopop", rd_ptr - p0, 0);
    chk("t6/idle", busy, 0);
    acq = 1'b0;
    tick(1);
    chk("t6/busy", busy, 1);
    chk("t6/rd_en", fifo_rd_en, 1);
    tick(2);
    acq = 1'b1;
    wait_done("t6", 1'b0);
    expect_fill("t6", ob, rb, h, 1, 1'b0);
    acq = 1'b0;

    // DDR never answers
    ob = out_n; rb = req_n;
    ddr_lat = 0;
    h = mk_hdr(8'hF1, 20'd2, 23'h000020);
    push(h);
    wait_done("t5", 1'b0);
    expect_fill("t5", ob, rb, h, 2, 1'b1);
    chk("t5/err", err, 1);
    ddr_lat = 5;
    ob = out_n; rb = req_n;
    h = mk_hdr(8'hF1, 20'd1, 23'h000030);
    push(h);
    wait_done("t5b", 1'b0);
    expect_fill("t5b", ob, rb, h, 1, 1'b0);
    chk("t5b/sticky", err, 1);

    // reset while waiting on DDR
    ob = out_n; rb = req_n;
    push(mk_hdr(8'hF1, 20'd3, 23'h000060));
    tick(4);
    reset_n = 1'b0;
    tick(10);
    chk("rs/busy", busy, 0);
    chk("rs/valid", valid, 0);
    chk("rs/req", one_burst, 0);
    chk("rs/err", err, 0);
    reset_n = 1'b1;
    tick(20);
    chk("rs/reqs", req_n - rb, 1);
    chk("rs/words", out_n - ob, 1);
    chk("rs/idle", busy, 0);
    chk("rs/err2", err, 0);

    // wrong tag
    ob = out_n; rb = req_n;
    h = mk_hdr(8'h00, 20'd1, 23'h000050);
    push(h);
    wait_done("t7", 1'b0);
    expect_fill("t7", ob, rb, h, 1, 1'b0);
    chk("t7/err", err, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
